// File: rtl/adc_fifo_drain_ctrl.sv
// adc_fifo_drain_ctrl: round-robin burst drain of N_CH ADC FIFOs into one channel-tagged
// valid/ready stream, plus sticky per-channel overflow flags and an interrupt.
module adc_fifo_drain_ctrl #(
   parameter int N_CH   = 4,
   parameter int W_FIFO = 4,
   parameter int W_DATA = 32,
   parameter int W_CH   = $clog2(N_CH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en_i,
   input  logic                       flush_i,
   input  logic [W_FIFO:0]            thresh_i,
   input  logic [W_FIFO:0]            burst_len_i,
   input  logic [N_CH*(W_FIFO+1)-1:0] fill_level_i,
   input  logic [N_CH-1:0]            ovflw_i,
   input  logic [N_CH*W_DATA-1:0]     data_i,
   output logic [N_CH-1:0]            read_req_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [W_DATA-1:0]          out_data_o,
   output logic [W_CH-1:0]            out_ch_o,
   output logic                       out_last_o,
   output logic                       busy_o,
   output logic [N_CH-1:0]            ovflw_flags_o,
   input  logic [N_CH-1:0]            ovflw_clr_i,
   output logic                       ovflw_irq_o
);
   localparam int LW = W_FIFO + 1;
   typedef enum logic [1:0] {IDLE, XFER, FLUSH_OUT} state_t;
   state_t state, state_nx;
   logic [LW-1:0] fill [N_CH];
   logic [W_DATA-1:0] word [N_CH];
   logic [N_CH-1:0] elig;
   logic [W_CH-1:0] rr_ptr, sel, grant_ch, scan;
   logic [LW-1:0] count, blen, fill_sel;
   logic grant_v, pop, last_pop, out_free;
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign fill[k] = fill_level_i[k*LW +: LW];
      assign word[k] = data_i[k*W_DATA +: W_DATA];
      assign elig[k] = (thresh_i != '0 && fill[k] >= thresh_i) || (flush_i && fill[k] != '0);
   end
   // lowest offset from rr_ptr wins, so scan downwards and let later hits overwrite
   always_comb begin
      grant_v = 1'b0;
      grant_ch = '0;
      scan = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         scan = W_CH'((int'(rr_ptr) + i) % N_CH);
         if (elig[scan]) begin
            grant_v = 1'b1;
            grant_ch = scan;
         end
      end
   end
   assign fill_sel = fill[sel];
   assign out_free = !out_valid_o || out_ready_i;
   assign pop = state == XFER && fill_sel != '0 && count < blen && out_free;
   assign last_pop = (count + 1'b1 == blen) || (fill_sel == LW'(1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (en_i && grant_v) state_nx = XFER;
         XFER:      if ((pop && last_pop) || fill_sel == '0) state_nx = FLUSH_OUT;
         FLUSH_OUT: if (out_free) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end
   always_comb begin
      read_req_o = '0;
      read_req_o[sel] = pop;
      busy_o = state != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         sel <= '0;
         count <= '0;
         blen <= '0;
      end else begin
         if (state == IDLE && state_nx == XFER) begin
            sel <= grant_ch;
            count <= '0;
            blen <= burst_len_i == '0 ? LW'(1) : burst_len_i;
         end else if (pop) begin
            count <= count + 1'b1;
         end
         if (state == FLUSH_OUT && state_nx == IDLE)
            rr_ptr <= sel == W_CH'(N_CH - 1) ? '0 : sel + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_o <= 1'b0;
         out_data_o <= '0;
         out_ch_o <= '0;
         out_last_o <= 1'b0;
         ovflw_flags_o <= '0;
         ovflw_irq_o <= 1'b0;
      end else begin
         if (pop) begin
            out_valid_o <= 1'b1;
            out_data_o <= word[sel];
            out_ch_o <= sel;
            out_last_o <= last_pop;
         end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
            out_data_o <= '0;
            out_ch_o <= '0;
            out_last_o <= 1'b0;
         end
         // a new overflow event beats a simultaneous clear
         ovflw_flags_o <= (ovflw_flags_o & ~ovflw_clr_i) | ovflw_i;
         ovflw_irq_o <= |ovflw_flags_o;
      end
   end
endmodule
